lemming_tool_arbiter: RTL and testbench
=======================================

Name: lemming_tool_arbiter

Overview:
- Round-robin arbiter that shares one digging tool among N lemming walker FSMs.
- Each walker raises req to use the tool; the arbiter grants exactly one walker at a time and enforces a maximum hold time.
- The granted walker switches from walking to digging; all others keep walking.
- Sits between the array of walker FSMs and the shared tool datapath.

Parameters:
- N, 4, number of requesting lemmings (2..16).
- MAX_HOLD, 8, maximum consecutive grant cycles before a forced release (1..255).
- IDW, $clog2(N), width of grant_id (minimum 1).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N  req[i]=1 when lemming i wants the tool.
- done  input  N  done[i]=1 pulse: lemming i voluntarily releases the tool.
- grant  output  N  one-hot or zero; grant[i]=1 means lemming i owns the tool.
- grant_id  output  IDW  index of the current owner; 0 when idle.
- busy  output  1  1 in GRANT state.
- timeout  output  1  one-cycle pulse on a forced release.

Behaviour:
- Reset: synchronous and active-high, sampled on the clk edge.
  - State=IDLE; grant=0, grant_id=0, busy=0, timeout=0.
  - RR pointer=0, so req[0] has first priority after reset.
  - Hold counter=0; all lockout bits cleared.
  - Reset asserted mid-GRANT drops grant on that same edge; there is no COOL cycle.
- States:
  - IDLE: no owner.
  - GRANT: one owner.
  - COOL: one mandatory idle cycle after every release.
- IDLE:
  - If any eligible req bit (req & ~lockout) is set, choose the first eligible index at or after the RR pointer, wrapping modulo N.
  - Next edge: grant[winner]=1, grant_id=winner, busy=1, hold counter=1, state=GRANT.
  - Latency: req sampled in cycle t gives grant in cycle t+1.
- GRANT, owner k:
  - Release on the first of: req[k]=0, done[k]=1, or hold counter==MAX_HOLD with req[k] still 1.
  - On release, next edge: grant=0, busy=0, RR pointer=(k+1) mod N, state=COOL.
  - done/req of non-owners are ignored in GRANT.
  - Otherwise the hold counter increments, saturating at MAX_HOLD.
- Forced release (MAX_HOLD reached):
  - timeout=1 for exactly the cycle after the release edge, i.e. the COOL cycle.
  - lockout[k] is set.
- Lockout:
  - lockout[k] clears on any edge where req[k]=0.
  - A locked-out lemming cannot win until it drops req at least one cycle.
- COOL:
  - Outputs idle; after one cycle return to IDLE.
  - Arbitration happens in IDLE, so the minimum gap between grants is 2 cycles (COOL + IDLE decision edge).
- Simultaneous requests: the RR pointer decides; no lemming waits more than N-1 other grants while continuously eligible.
- Invariants:
  - grant is never multi-hot.
  - grant is never nonzero outside GRANT.
  - grant_id is meaningful only when busy=1.
- The arbiter never asserts grant to a lemming whose req was 0 in the deciding cycle.

Optional Feature:
- LEMMING_ARB_PRIO_EN defined:
  - Lemming 0 is a priority requester: in IDLE, an eligible req[0] wins regardless of the RR pointer.
  - Lemming 0 is still subject to MAX_HOLD and lockout.
  - The RR pointer is not updated when lemming 0's grant releases.
- Not defined: pure round-robin as above; index 0 has no special treatment.

Test Plan:
- Reset then single request: reset=1 for 2 cycles, then req=4'b0100 held → grant=4'b0100 and grant_id=2 one cycle later, busy=1. Drop req → grant=0 next edge, 1 COOL cycle.
- Round-robin fairness: N=4, req=4'b1111 held, each owner pulses done after 2 grant cycles → grant order 0,1,2,3,0 with a 2-cycle gap between grants.
- Timeout: MAX_HOLD=8, req=4'b0001 held forever → grant[0] for exactly 8 cycles, timeout pulses once, then no regrant. Drop req for 1 cycle and reassert → regrant.
- Timeout with a contender: req=4'b0011 held, lemming 0 times out → lemming 1 granted 2 cycles after release. Lemming 0 stays locked out until its req drops.
- Reset mid-operation: lemming 3 granted for 3 cycles, assert reset → grant=0 and busy=0 on that edge. After release with req=4'b1001, lemming 0 wins.
- Priority macro (LEMMING_ARB_PRIO_EN): pointer at 2, req=4'b0101 → lemming 0 granted first. Without the macro → lemming 2 granted first.

Source files
------------

// File: rtl/lemming_tool_arbiter_if.sv
// Handshake bundle between the lemming walker array and the digging-tool arbiter.
// master = walker side (drives req/done), slave = arbiter side (drives grant status).
interface lemming_tool_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]   req;
  logic [N-1:0]   done;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic           timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  grant_id,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_id,
    output busy,
    output timeout
  );
endinterface

// File: rtl/lemming_tool_arbiter.sv
// Round-robin arbiter sharing one digging tool among N walkers, with hold-time limit and lockout.
// Optional: define LEMMING_ARB_PRIO_EN to give lemming 0 fixed priority in IDLE.
module lemming_tool_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  lemming_tool_arbiter_if.slave bus
);

  localparam int HOLD_W = 8;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [IDW-1:0]    LAST_ID  = IDW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_COOL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDW-1:0]      owner_q, owner_d;
  logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [N-1:0]        lockout_q, lockout_d;
  logic                timeout_q, timeout_d;

  logic [N-1:0]        eligible;
  logic [IDW-1:0]      winner;
  logic                owner_req;
  logic                owner_done;
  logic                at_max;
  logic                vol_rel;
  logic                forced_rel;

  // First eligible index at or after ptr, wrapping modulo N.
  function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] elig,
                                             input logic [IDW-1:0] ptr);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IDW-1:0] off;
    logic [IDW:0]   sum;
    dbl = {elig, elig} >> ptr;
    rot = dbl[N-1:0];
    off = '0;
    for (int o = N - 1; o >= 0; o--) begin
      if (rot[o]) off = IDW'(o);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IDW+1)'(N)) sum = sum - (IDW+1)'(N);
    return sum[IDW-1:0];
  endfunction

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] k);
    return (k == LAST_ID) ? '0 : k + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      hold_q    <= '0;
      lockout_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      hold_q    <= hold_d;
      lockout_q <= lockout_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    eligible   = bus.req & ~lockout_q;
    owner_req  = bus.req[owner_q];
    owner_done = bus.done[owner_q];
    at_max     = (hold_q == HOLD_MAX);
    // A voluntary release (req drop or done) takes precedence over a coincident timeout.
    vol_rel    = !owner_req || owner_done;
    forced_rel = !vol_rel && at_max;

`ifdef LEMMING_ARB_PRIO_EN
    winner = eligible[0] ? '0 : rr_pick(eligible, rr_ptr_q);
`else
    winner = rr_pick(eligible, rr_ptr_q);
`endif

    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    hold_d    = hold_q;
    lockout_d = lockout_q & bus.req;
    timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          state_d = ST_GRANT;
          owner_d = winner;
          hold_d  = HOLD_W'(1);
        end
      end
      ST_GRANT: begin
        if (vol_rel || forced_rel) begin
          state_d = ST_COOL;
          hold_d  = '0;
`ifdef LEMMING_ARB_PRIO_EN
          if (owner_q != '0) rr_ptr_d = next_id(owner_q);
`else
          rr_ptr_d = next_id(owner_q);
`endif
          if (forced_rel) begin
            timeout_d          = 1'b1;
            lockout_d[owner_q] = 1'b1;
          end
        end else if (!at_max) begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_COOL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.grant    = '0;
    bus.grant_id = '0;
    bus.busy     = 1'b0;
    bus.timeout  = timeout_q;
    if (state_q == ST_GRANT) begin
      bus.grant[owner_q] = 1'b1;
      bus.grant_id       = owner_q;
      bus.busy           = 1'b1;
    end
  end

endmodule

// File: tb/tb_lemming_tool_arbiter.sv
// Testbench for lemming_tool_arbiter: directed vector table plus randomized run against a reference model.
module tb_lemming_tool_arbiter;
  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
  localparam int IDW      = 2;
`ifdef LEMMING_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lemming_tool_arbiter_if #(.N(N), .IDW(IDW)) bus ();

  lemming_tool_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .IDW(IDW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    bit         rst;
    logic [3:0] req;
    logic [3:0] done;
    int         rep;
    logic [3:0] g;
    bit         t;
  } vec_t;

  vec_t tbl[$];

  // Reference model state: who owns the tool, how long, pending idle gap, pointer, lockouts.
  int       m_owner;
  int       m_held;
  int       m_ptr;
  bit       m_cool;
  bit       m_tmo;
  bit [3:0] m_lock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic void add(input bit rst, input logic [3:0] req, input logic [3:0] done,
                              input int rep, input logic [3:0] g, input bit t);
    vec_t v;
    v.rst = rst; v.req = req; v.done = done; v.rep = rep; v.g = g; v.t = t;
    tbl.push_back(v);
  endfunction

  function automatic int id_of(input logic [3:0] g);
    int id;
    id = 0;
    for (int i = 0; i < N; i++) if (g[i]) id = i;
    return id;
  endfunction

  task automatic model_step(input bit rst, input logic [3:0] r, input logic [3:0] d);
    int k;
    int w;
    int idx;
    bit [3:0] elig;
    if (rst) begin
      m_owner = -1; m_held = 0; m_ptr = 0; m_cool = 0; m_tmo = 0; m_lock = '0;
      return;
    end
    m_tmo  = 0;
    elig   = r & ~m_lock;
    m_lock = m_lock & r;
    if (m_owner >= 0) begin
      k = m_owner;
      if (!r[k] || d[k] || m_held == MAX_HOLD) begin
        if (r[k] && !d[k]) begin
          m_tmo     = 1;
          m_lock[k] = 1'b1;
        end
        m_owner = -1;
        m_held  = 0;
        m_cool  = 1;
        if (!(PRIO && k == 0)) m_ptr = (k + 1) % N;
      end else begin
        m_held++;
      end
    end else if (m_cool) begin
      m_cool = 0;
    end else begin
      w = -1;
      if (PRIO && elig[0]) w = 0;
      else begin
        for (int o = 0; o < N; o++) begin
          idx = (m_ptr + o) % N;
          if (w < 0 && elig[idx]) w = idx;
        end
      end
      if (w >= 0) begin
        m_owner = w;
        m_held  = 1;
      end
    end
  endtask

  task automatic step(input bit rs, input logic [3:0] r, input logic [3:0] d);
    reset    = rs;
    bus.req  = r;
    bus.done = d;
    @(posedge clk);
    model_step(rs, r, d);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    logic [3:0] rr_req;
    logic [3:0] prio_exp;
    logic [3:0] r;
    logic [3:0] d;
    bit         rs;
    int         first;

    reset    = 1'b1;
    bus.req  = '0;
    bus.done = '0;
    @(negedge clk);

    rr_req   = PRIO ? 4'b1110 : 4'b1111;
    first    = PRIO ? 1 : 0;
    prio_exp = PRIO ? 4'b0001 : 4'b0100;

    // reset, single request, release and cool-down
    add(1, 4'b0000, 4'b0000, 2, 4'b0000, 0);
    add(0, 4'b0100, 4'b0000, 2, 4'b0100, 0);
    add(0, 4'b0000, 4'b0000, 2, 4'b0000, 0);
    // round robin with done after two grant cycles
    add(1, 4'b0000, 4'b0000, 1, 4'b0000, 0);
    for (int k = first; k < N; k++) begin
      add(0, rr_req, 4'b0000, 2, 4'(1 << k), 0);
      add(0, rr_req, 4'(1 << k), 1, 4'b0000, 0);
      add(0, rr_req, 4'b0000, 1, 4'b0000, 0);
    end
    add(0, rr_req, 4'b0000, 1, 4'(1 << first), 0);
    add(0, rr_req, 4'(1 << first), 1, 4'b0000, 0);
    // lone requester hits the hold limit and is locked out
    add(1, 4'b0000, 4'b0000, 1, 4'b0000, 0);
    add(0, 4'b0001, 4'b0000, 8, 4'b0001, 0);
    add(0, 4'b0001, 4'b0000, 1, 4'b0000, 1);
    add(0, 4'b0001, 4'b0000, 3, 4'b0000, 0);
    add(0, 4'b0000, 4'b0000, 1, 4'b0000, 0);
    add(0, 4'b0001, 4'b0000, 1, 4'b0001, 0);
    add(0, 4'b0000, 4'b0000, 2, 4'b0000, 0);
    // timeout with a contender
    add(1, 4'b0000, 4'b0000, 1, 4'b0000, 0);
    add(0, 4'b0011, 4'b0000, 8, 4'b0001, 0);
    add(0, 4'b0011, 4'b0000, 1, 4'b0000, 1);
    add(0, 4'b0011, 4'b0000, 1, 4'b0000, 0);
    add(0, 4'b0011, 4'b0000, 1, 4'b0010, 0);
    add(0, 4'b0011, 4'b0010, 1, 4'b0000, 0);
    add(0, 4'b0011, 4'b0000, 1, 4'b0000, 0);
    add(0, 4'b0011, 4'b0000, 1, 4'b0010, 0);
    add(0, 4'b0000, 4'b0000, 2, 4'b0000, 0);
    // reset in the middle of a grant
    add(1, 4'b0000, 4'b0000, 1, 4'b0000, 0);
    add(0, 4'b1000, 4'b0000, 3, 4'b1000, 0);
    add(1, 4'b1001, 4'b0000, 1, 4'b0000, 0);
    add(0, 4'b1001, 4'b0000, 1, 4'b0001, 0);
    add(0, 4'b0000, 4'b0000, 2, 4'b0000, 0);
    // pointer moved to 2, then lemmings 0 and 2 compete
    add(1, 4'b0000, 4'b0000, 1, 4'b0000, 0);
    add(0, 4'b0010, 4'b0000, 1, 4'b0010, 0);
    add(0, 4'b0000, 4'b0000, 1, 4'b0000, 0);
    add(0, 4'b0101, 4'b0000, 1, 4'b0000, 0);
    add(0, 4'b0101, 4'b0000, 1, prio_exp, 0);
    add(0, 4'b0000, 4'b0000, 2, 4'b0000, 0);

    foreach (tbl[i]) begin
      for (int j = 0; j < tbl[i].rep; j++) begin
        step(tbl[i].rst, tbl[i].req, tbl[i].done);
        chk("vec_grant",    32'(bus.grant),    32'(tbl[i].g));
        chk("vec_grant_id", 32'(bus.grant_id), 32'(id_of(tbl[i].g)));
        chk("vec_busy",     32'(bus.busy),     32'(|tbl[i].g));
        chk("vec_timeout",  32'(bus.timeout),  32'(tbl[i].t));
      end
    end

    // randomized run against the reference model
    r = '0;
    step(1'b1, 4'b0000, 4'b0000);
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      end
      d  = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      rs = ($urandom_range(0, 299) == 0);
      step(rs, r, d);
      chk("rnd_grant",    32'(bus.grant),    (m_owner >= 0) ? 32'(1 << m_owner) : 32'd0);
      chk("rnd_grant_id", 32'(bus.grant_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
      chk("rnd_busy",     32'(bus.busy),     32'(m_owner >= 0));
      chk("rnd_timeout",  32'(bus.timeout),  32'(m_tmo));
      chk("rnd_onehot0",  32'($onehot0(bus.grant)), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
